// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS-subset control unit: FETCH/DECODE/EXE/MEM/WB sequencer with a sticky
// trap on unsupported encodings and a retired-instruction counter.
module mc_ctrl_fsm (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  op,
    input  logic [5:0]  fun,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic        reg_we,
    output logic [1:0]  reg_dst,
    output logic [1:0]  wd_sel,
    output logic        alu_src_b,
    output logic [1:0]  ext_op,
    output logic [1:0]  alu_op,
    output logic        mem_re,
    output logic        mem_we,
    output logic        illegal,
    output logic [31:0] instr_cnt,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXE    = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] instr_cnt_q, instr_cnt_d;
    logic        illegal_q, illegal_d;

    logic is_rtype, is_addu, is_subu, is_jr;
    logic is_beq, is_lui, is_lw, is_ori, is_sw, is_j, is_jal, is_legal;

    assign is_rtype = (op == 6'b000000);
    assign is_addu  = is_rtype && (fun == 6'b100001);
    assign is_subu  = is_rtype && (fun == 6'b100011);
    assign is_jr    = is_rtype && (fun == 6'b001000);
    assign is_beq   = (op == 6'b000100);
    assign is_lui   = (op == 6'b001111);
    assign is_lw    = (op == 6'b100011);
    assign is_ori   = (op == 6'b001101);
    assign is_sw    = (op == 6'b101011);
    assign is_j     = (op == 6'b000010);
    assign is_jal   = (op == 6'b000011);
    assign is_legal = is_addu | is_subu | is_jr | is_beq | is_lui | is_lw |
                      is_ori | is_sw | is_j | is_jal;

    // Outputs decode from the current state; beq's pc_we and the MEM exit need zero and
    // mem_ready in the same cycle, so they cannot be pre-registered.
    always_comb begin
        state_d     = state_q;
        instr_cnt_d = instr_cnt_q;
        illegal_d   = illegal_q;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        pc_src      = 2'd0;
        reg_we      = 1'b0;
        reg_dst     = 2'd0;
        wd_sel      = 2'd0;
        alu_src_b   = 1'b0;
        ext_op      = 2'd0;
        alu_op      = 2'd0;
        mem_re      = 1'b0;
        mem_we      = 1'b0;

        case (state_q)
            S_FETCH: begin
                ir_we   = 1'b1;
                pc_we   = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (is_j) begin
                    pc_we   = 1'b1;
                    pc_src  = 2'd2;
                    state_d = S_FETCH;
                end else if (is_jal) begin
                    pc_we   = 1'b1;
                    pc_src  = 2'd2;
                    reg_we  = 1'b1;
                    reg_dst = 2'd2;
                    wd_sel  = 2'd2;
                    state_d = S_FETCH;
                end else if (is_jr) begin
                    pc_we   = 1'b1;
                    pc_src  = 2'd3;
                    state_d = S_FETCH;
                end else if (!is_legal) begin
                    illegal_d = 1'b1;
                    state_d   = S_TRAP;
                end else begin
                    state_d = S_EXE;
                end
            end
            S_EXE: begin
                if (is_addu || is_subu) begin
                    alu_op  = is_subu ? 2'd1 : 2'd0;
                    state_d = S_WB;
                end else if (is_ori || is_lui) begin
                    alu_src_b = 1'b1;
                    ext_op    = is_lui ? 2'd2 : 2'd0;
                    alu_op    = 2'd2;
                    state_d   = S_WB;
                end else if (is_lw || is_sw) begin
                    alu_src_b = 1'b1;
                    ext_op    = 2'd1;
                    state_d   = S_MEM;
                end else begin
                    alu_op  = 2'd1;
                    pc_src  = 2'd1;
                    pc_we   = is_beq & zero;
                    state_d = S_FETCH;
                end
            end
            S_MEM: begin
                if (is_lw) begin
                    mem_re = 1'b1;
                    if (mem_ready) state_d = S_WB;
                end else if (is_sw) begin
                    mem_we = 1'b1;
                    if (mem_ready) state_d = S_FETCH;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_WB: begin
                reg_we  = 1'b1;
                reg_dst = (is_addu || is_subu) ? 2'd1 : 2'd0;
                wd_sel  = is_lw ? 2'd1 : 2'd0;
                state_d = S_FETCH;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // A retire is any return to FETCH from a working state; TRAP never retires.
        if (state_d == S_FETCH && state_q != S_FETCH && state_q != S_TRAP &&
            state_q inside {S_DECODE, S_EXE, S_MEM, S_WB})
            instr_cnt_d = instr_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_FETCH;
            instr_cnt_q <= 32'd0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            instr_cnt_q <= instr_cnt_d;
            illegal_q   <= illegal_d;
        end
    end

    assign illegal   = illegal_q;
    assign instr_cnt = instr_cnt_q;
    assign state     = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Table-driven cycle vectors through a scoreboard queue, plus latency runs with
// variable memory wait for the multi-cycle instructions.
module tb_mc_ctrl_fsm;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  op, fun;
    logic        zero, mem_ready;
    logic        ir_we, pc_we, reg_we, alu_src_b, mem_re, mem_we, illegal;
    logic [1:0]  pc_src, reg_dst, wd_sel, ext_op, alu_op;
    logic [31:0] instr_cnt;
    logic [2:0]  state;

    always #5 clk = ~clk;

    mc_ctrl_fsm dut (
        .clk(clk), .reset(reset), .op(op), .fun(fun), .zero(zero), .mem_ready(mem_ready),
        .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we), .reg_dst(reg_dst),
        .wd_sel(wd_sel), .alu_src_b(alu_src_b), .ext_op(ext_op), .alu_op(alu_op),
        .mem_re(mem_re), .mem_we(mem_we), .illegal(illegal), .instr_cnt(instr_cnt),
        .state(state)
    );

    localparam logic [5:0] OP_R = 6'b000000, OP_BEQ = 6'b000100, OP_LUI = 6'b001111;
    localparam logic [5:0] OP_LW = 6'b100011, OP_ORI = 6'b001101, OP_SW = 6'b101011;
    localparam logic [5:0] OP_J = 6'b000010, OP_JAL = 6'b000011, OP_BAD = 6'b111111;
    localparam logic [5:0] F_ADDU = 6'b100001, F_SUBU = 6'b100011, F_JR = 6'b001000;

    typedef struct {
        logic        chk;
        logic        rst_n;
        logic [5:0]  op;
        logic [5:0]  fun;
        logic        zero;
        logic        rdy;
        logic [2:0]  st;
        logic [16:0] ctl;
        logic [31:0] cnt;
        string       tag;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [16:0] ctl_act;
    assign ctl_act = {ir_we, pc_we, pc_src, reg_we, reg_dst, wd_sel, alu_src_b,
                      ext_op, alu_op, mem_re, mem_we, illegal};

    logic [16:0] c_fetch, c_none, c_subu, c_ori, c_lui, c_addr, c_beq0, c_beq1;
    logic [16:0] c_lwm, c_swm, c_wb_rd, c_wb_rt, c_wb_lw, c_j, c_jal, c_jr, c_trap;

    function automatic logic [16:0] c(input int ir, pc, pcs, rw, rd, wd, asb, ext, aop,
                                      mre, mwe, ill);
        return {ir[0], pc[0], pcs[1:0], rw[0], rd[1:0], wd[1:0], asb[0], ext[1:0],
                aop[1:0], mre[0], mwe[0], ill[0]};
    endfunction

    task automatic add(input int chk, rst_n, input logic [5:0] o, f, input int z, rdy, st,
                       input logic [16:0] ctl, input int cnt, input string tag);
        vec_t v;
        v.chk = chk[0]; v.rst_n = rst_n[0]; v.op = o; v.fun = f; v.zero = z[0];
        v.rdy = rdy[0]; v.st = st[2:0]; v.ctl = ctl; v.cnt = cnt; v.tag = tag;
        vecs.push_back(v);
    endtask

    task automatic alu4(input logic [5:0] o, f, input logic [16:0] ce, cw, input int cnt,
                        input string tag);
        add(1, 1, o, f, 0, 0, 0, c_fetch, cnt, {tag, "_F"});
        add(1, 1, o, f, 0, 0, 1, c_none,  cnt, {tag, "_D"});
        add(1, 1, o, f, 0, 0, 2, ce,      cnt, {tag, "_E"});
        add(1, 1, o, f, 0, 0, 4, cw,      cnt, {tag, "_W"});
    endtask

    task automatic check(input string nm, input logic [31:0] act, exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic run_lat(input logic [5:0] o, f, input logic z, input int n,
                           input int exp_lat, input string nm);
        int          cyc = 0;
        int          mc = 0;
        logic [31:0] c0;
        @(negedge clk);
        op = o; fun = f; zero = z;
        c0 = instr_cnt;
        forever begin
            mem_ready = (state == 3'd3) && (mc == n - 1);
            if (state == 3'd3) mc++;
            cyc++;
            @(posedge clk);
            #1;
            if (state == 3'd0 || cyc >= 50) break;
            @(negedge clk);
        end
        mem_ready = 1'b0;
        check({nm, "_latency"}, 32'(cyc), 32'(exp_lat));
        check({nm, "_retire"}, instr_cnt, c0 + 32'd1);
        $display("lat %s N=%0d cycles=%0d cnt=%0d", nm, n, cyc, instr_cnt);
    endtask

    initial begin
        reset = 1'b0; op = '0; fun = '0; zero = 1'b0; mem_ready = 1'b0;

        c_fetch = c(1,1,0,0,0,0,0,0,0,0,0,0);
        c_none  = c(0,0,0,0,0,0,0,0,0,0,0,0);
        c_subu  = c(0,0,0,0,0,0,0,0,1,0,0,0);
        c_ori   = c(0,0,0,0,0,0,1,0,2,0,0,0);
        c_lui   = c(0,0,0,0,0,0,1,2,2,0,0,0);
        c_addr  = c(0,0,0,0,0,0,1,1,0,0,0,0);
        c_beq0  = c(0,0,1,0,0,0,0,0,1,0,0,0);
        c_beq1  = c(0,1,1,0,0,0,0,0,1,0,0,0);
        c_lwm   = c(0,0,0,0,0,0,0,0,0,1,0,0);
        c_swm   = c(0,0,0,0,0,0,0,0,0,0,1,0);
        c_wb_rd = c(0,0,0,1,1,0,0,0,0,0,0,0);
        c_wb_rt = c(0,0,0,1,0,0,0,0,0,0,0,0);
        c_wb_lw = c(0,0,0,1,0,1,0,0,0,0,0,0);
        c_j     = c(0,1,2,0,0,0,0,0,0,0,0,0);
        c_jal   = c(0,1,2,1,2,2,0,0,0,0,0,0);
        c_jr    = c(0,1,3,0,0,0,0,0,0,0,0,0);
        c_trap  = c(0,0,0,0,0,0,0,0,0,0,0,1);

        add(0, 0, OP_R, F_ADDU, 0, 0, 0, c_none, 0, "reset");
        alu4(OP_R, F_ADDU, c_none, c_wb_rd, 0, "addu");
        alu4(OP_R, F_SUBU, c_subu, c_wb_rd, 1, "subu");
        alu4(OP_ORI, 6'd0, c_ori, c_wb_rt, 2, "ori");
        alu4(OP_LUI, 6'd0, c_lui, c_wb_rt, 3, "lui");
        // mem_ready high outside MEM must be ignored
        add(1, 1, OP_LW, 6'd0, 0, 1, 0, c_fetch, 4, "lw_F");
        add(1, 1, OP_LW, 6'd0, 0, 1, 1, c_none,  4, "lw_D");
        add(1, 1, OP_LW, 6'd0, 0, 1, 2, c_addr,  4, "lw_E");
        add(1, 1, OP_LW, 6'd0, 0, 0, 3, c_lwm,   4, "lw_M0");
        add(1, 1, OP_LW, 6'd0, 0, 0, 3, c_lwm,   4, "lw_M1");
        add(1, 1, OP_LW, 6'd0, 0, 1, 3, c_lwm,   4, "lw_M2");
        add(1, 1, OP_LW, 6'd0, 0, 0, 4, c_wb_lw, 4, "lw_W");
        add(1, 1, OP_SW, 6'd0, 0, 0, 0, c_fetch, 5, "sw_F");
        add(1, 1, OP_SW, 6'd0, 0, 0, 1, c_none,  5, "sw_D");
        add(1, 1, OP_SW, 6'd0, 0, 0, 2, c_addr,  5, "sw_E");
        add(1, 1, OP_SW, 6'd0, 0, 1, 3, c_swm,   5, "sw_M");
        add(1, 1, OP_BEQ, 6'd0, 1, 0, 0, c_fetch, 6, "beq0_F");
        add(1, 1, OP_BEQ, 6'd0, 1, 0, 1, c_none,  6, "beq0_D");
        add(1, 1, OP_BEQ, 6'd0, 0, 0, 2, c_beq0,  6, "beq0_E");
        add(1, 1, OP_BEQ, 6'd0, 0, 0, 0, c_fetch, 7, "beq1_F");
        add(1, 1, OP_BEQ, 6'd0, 1, 0, 1, c_none,  7, "beq1_D");
        add(1, 1, OP_BEQ, 6'd0, 1, 0, 2, c_beq1,  7, "beq1_E");
        add(1, 1, OP_J,   6'd0, 0, 0, 0, c_fetch, 8, "j_F");
        add(1, 1, OP_J,   6'd0, 0, 0, 1, c_j,     8, "j_D");
        add(1, 1, OP_JAL, 6'd0, 0, 0, 0, c_fetch, 9, "jal_F");
        add(1, 1, OP_JAL, 6'd0, 0, 0, 1, c_jal,   9, "jal_D");
        add(1, 1, OP_R,   F_JR, 0, 0, 0, c_fetch, 10, "jr_F");
        add(1, 1, OP_R,   F_JR, 0, 0, 1, c_jr,    10, "jr_D");
        add(1, 1, OP_BAD, 6'd0, 0, 0, 0, c_fetch, 11, "bad_F");
        add(1, 1, OP_BAD, 6'd0, 0, 0, 1, c_none,  11, "bad_D");
        for (int k = 0; k < 10; k++)
            add(1, 1, (k < 5) ? OP_BAD : OP_J, 6'd0, k % 2, (k + 1) % 2, 5, c_trap, 11,
                "trap");
        add(1, 0, OP_BAD, 6'd0, 0, 0, 5, c_trap,  11, "trap_rst");
        add(1, 1, OP_J,   6'd0, 0, 0, 0, c_fetch, 0,  "post_trap_F");
        add(1, 1, OP_J,   6'd0, 0, 0, 1, c_j,     0,  "j2_D");
        add(1, 1, OP_SW,  6'd0, 0, 0, 0, c_fetch, 1,  "swr_F");
        add(1, 1, OP_SW,  6'd0, 0, 0, 1, c_none,  1,  "swr_D");
        add(1, 1, OP_SW,  6'd0, 0, 0, 2, c_addr,  1,  "swr_E");
        add(1, 1, OP_SW,  6'd0, 0, 0, 3, c_swm,   1,  "swr_M0");
        add(1, 0, OP_SW,  6'd0, 0, 1, 3, c_swm,   1,  "swr_M_rst");
        add(1, 1, OP_SW,  6'd0, 0, 0, 0, c_fetch, 0,  "swr_after");

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t e;
            @(negedge clk);
            reset = vecs[i].rst_n; op = vecs[i].op; fun = vecs[i].fun;
            zero = vecs[i].zero; mem_ready = vecs[i].rdy;
            sb.push_back(vecs[i]);
            #1;
            e = sb.pop_front();
            if (e.chk) begin
                check({e.tag, "_state"}, 32'(state), 32'(e.st));
                check({e.tag, "_ctl"}, 32'(ctl_act), 32'(e.ctl));
                check({e.tag, "_cnt"}, instr_cnt, e.cnt);
                $display("vec %0d %s state=%0d ctl=%05h cnt=%0d", i, e.tag, state,
                         ctl_act, instr_cnt);
            end
        end

        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        run_lat(OP_LW, 6'd0, 1'b0, 1, 5, "lw_n1");
        run_lat(OP_LW, 6'd0, 1'b0, 4, 8, "lw_n4");
        run_lat(OP_SW, 6'd0, 1'b0, 3, 6, "sw_n3");
        run_lat(OP_R, F_SUBU, 1'b0, 1, 4, "subu");
        run_lat(OP_BEQ, 6'd0, 1'b1, 1, 3, "beq");
        run_lat(OP_R, F_JR, 1'b0, 1, 2, "jr");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_fsm.md
MC_CTRL_FSM -- requirements
Module: mc_ctrl_fsm

Interface
REQ-001 The block SHALL have exactly one clock, `clk`, and a synchronous, active-low reset, `reset`.
REQ-002 Port list SHALL be as follows (name, direction, width, meaning):
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-low reset.
- op  in  6  IR[31:26]; valid from DECODE onward.
- fun  in  6  IR[5:0]; valid from DECODE onward.
- zero  in  1  ALU equal flag; sampled in EXE.
- mem_ready  in  1  data memory done for the current access.
- ir_we  out  1  load IR.
- pc_we  out  1  load PC.
- pc_src  out  2  PC source: 0 = PC+4, 1 = branch target, 2 = jump target, 3 = GPR[rs].
- reg_we  out  1  GRF write enable.
- reg_dst  out  2  write register: 0 = rt, 1 = rd, 2 = $31.
- wd_sel  out  2  write data: 0 = ALU, 1 = memory, 2 = latched PC+4.
- alu_src_b  out  1  ALU B input: 0 = GPR[rt], 1 = extended immediate.
- ext_op  out  2  immediate extension: 0 = zero, 1 = sign, 2 = upper (imm<<16).
- alu_op  out  2  ALU operation: 0 = add, 1 = sub, 2 = or.
- mem_re  out  1  data memory read request.
- mem_we  out  1  data memory write request.
- illegal  out  1  sticky unsupported-instruction flag.
- instr_cnt  out  32  count of retired instructions.
- state  out  3  current state code, for debug.

Function
REQ-003 Decode SHALL be combinational from op and fun and SHALL recognise only the following instructions.
- R-type (op=000000) with fun=100001 (addu), 100011 (subu) or 001000 (jr).
- op=000100 beq, 001111 lui, 100011 lw, 001101 ori, 101011 sw, 000010 j, 000011 jal.
- Every other encoding SHALL be treated as illegal.
REQ-004 State codes SHALL be: FETCH=0, DECODE=1, EXE=2, MEM=3, WB=4, TRAP=5.
REQ-005 FETCH SHALL assert ir_we=1, pc_we=1 and pc_src=0, then go to DECODE unconditionally.
REQ-006 DECODE SHALL act per instruction class.
- j: pc_we=1, pc_src=2, then FETCH.
- jal: pc_we=1, pc_src=2, reg_we=1, reg_dst=2, wd_sel=2, then FETCH.
- jr: pc_we=1, pc_src=3, then FETCH.
- illegal: go to TRAP.
- all others: go to EXE.
REQ-007 EXE SHALL drive the ALU per instruction.
- addu/subu: alu_src_b=0, alu_op=0/1 respectively, then WB.
- ori: alu_src_b=1, ext_op=0, alu_op=2, then WB.
- lui: alu_src_b=1, ext_op=2, alu_op=2, then WB.
- lw/sw: alu_src_b=1, ext_op=1, alu_op=0, then MEM.
- beq: alu_src_b=0, alu_op=1, pc_src=1, pc_we=zero, then FETCH.
REQ-008 MEM SHALL hold the memory request until mem_ready=1.
- lw: mem_re=1 every cycle in MEM; stay while mem_ready=0; go to WB on the cycle mem_ready=1.
- sw: mem_we=1 every cycle in MEM; stay while mem_ready=0; go to FETCH on the cycle mem_ready=1.
- mem_ready SHALL be ignored in all other states.
REQ-009 WB SHALL assert reg_we=1 with the following selects, then go to FETCH.
- addu/subu: reg_dst=1, wd_sel=0.
- ori/lui: reg_dst=0, wd_sel=0.
- lw: reg_dst=0, wd_sel=1.
REQ-010 TRAP SHALL be absorbing until reset: all enables stay 0, illegal=1, and instr_cnt is frozen.
REQ-011 Every enable (ir_we, pc_we, reg_we, mem_re, mem_we) not explicitly asserted in a state SHALL be 0; select outputs not specified are don't-care but SHALL be driven to 0.
REQ-012 instr_cnt SHALL increment by 1 on each transition into FETCH from DECODE, EXE, MEM or WB, and SHALL wrap from 0xFFFFFFFF to 0.
REQ-013 Latency SHALL be fixed per instruction, where N is the number of MEM cycles (≥1).
- j/jal/jr: 2 cycles.
- beq: 3 cycles.
- addu/subu/ori/lui: 4 cycles.
- sw: 3+N cycles.
- lw: 4+N cycles.

Reset
REQ-014 When reset=0 at a rising clk edge, the block SHALL set state=FETCH, instr_cnt=0 and illegal=0, overriding every other transition, including mid-MEM and TRAP.
REQ-015 In the cycle after reset, the outputs SHALL be the FETCH values: ir_we=1, pc_we=1, all other enables 0.

Verification
REQ-016 The bench SHALL cover the following directed scenarios.
- addu (op=0, fun=100001): states 0,1,2,4,0; reg_we=1 with reg_dst=1 only in WB; instr_cnt 0→1.
- lw with mem_ready low 2 cycles then high: state 3 held 3 cycles, mem_re=1 throughout; WB wd_sel=1; total 7 cycles.
- beq with zero=0, then beq with zero=1: EXE pc_we=0, then pc_we=1 with pc_src=1; both retire.
- jal: DECODE asserts pc_we=1, reg_we=1, reg_dst=2, wd_sel=2; back in FETCH after 2 cycles.
- op=111111: DECODE→TRAP; illegal=1; instr_cnt unchanged for 10 cycles; reset=0 clears to FETCH, illegal=0.
- sw with reset=0 asserted while in MEM: next cycle state=0, mem_we=0, instr_cnt=0.
